// File: rtl/whack_pkg.sv
// Shared types and constants for the whack-a-mole button event front end.
// Release events are enabled by defining WHACK_RELEASE_EVT_EN.
package whack_pkg;

  localparam int N_BTN_DEF    = 4;
  localparam int DEBOUNCE_SIM = 4;
  // wide enough for the largest panel (8 channels)
  localparam int EVT_ID_W     = 3;

  function automatic int ID_W(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic                rel;
    logic [EVT_ID_W-1:0] id;
  } btn_evt_t;

endpackage

// File: rtl/btn_debounce.sv
// One button channel: two-flop synchronizer, stability counter, stable flop.
// fall/rise strobe on the edge where the stable level flips.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic stable,
  output logic fall,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;
  logic          diff;
  logic          done;

  assign diff = (s2 != stable);
  assign done = diff && (cnt == CNT_LAST);
  assign fall = done && !s2;
  assign rise = done && s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1     <= 1'b1;
      s2     <= 1'b1;
      stable <= 1'b1;
      cnt    <= '0;
    end else begin
      s1 <= btn_n;
      s2 <= s1;
      if (done) begin
        stable <= s2;
        cnt    <= '0;
      end else if (diff) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/whack_btn_events.sv
// Debounced button press events queued into a FIFO with valid/ready output.
// Define WHACK_RELEASE_EVT_EN to also queue release events (press_rel=1).
module whack_btn_events
  import whack_pkg::*;
#(
  parameter int N_BTN           = N_BTN_DEF,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_BTN-1:0]       btn_n,
  output logic [N_BTN-1:0]       held,
  output logic                   press_valid,
  input  logic                   press_ready,
  output logic [ID_W(N_BTN)-1:0] press_id,
  output logic                   press_rel,
  output logic                   overflow,
  input  logic                   clear_overflow
);

  localparam int IW = ID_W(N_BTN);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW-1:0] PTR_LAST = AW'(FIFO_DEPTH - 1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);

  logic [N_BTN-1:0] stable;
  logic [N_BTN-1:0] fall;
  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] pend_press;
  logic [N_BTN-1:0] clr_press;
  logic [N_BTN-1:0] take_press;
  logic             ovf_set;

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk   (clk),
      .reset (reset),
      .btn_n (btn_n[g]),
      .stable(stable[g]),
      .fall  (fall[g]),
      .rise  (rise[g])
    );
  end

  assign held = ~stable;

  btn_evt_t         mem [FIFO_DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count;
  logic             full;
  logic             pop;
  logic             push;
  logic             sel_valid;
  btn_evt_t         sel_evt;
  btn_evt_t         head;
  logic             head_unused;

  assign full        = (count == CNT_FULL);
  assign press_valid = (count != '0);
  assign pop         = press_valid && press_ready;
  assign push        = sel_valid && (!full || pop);
  assign head        = mem[rptr];
  assign press_id    = head.id[IW-1:0];
  assign head_unused = ^{head.id, head.rel};

`ifdef WHACK_RELEASE_EVT_EN
  logic [N_BTN-1:0] pend_rel;
  logic [N_BTN-1:0] clr_rel;
  logic [N_BTN-1:0] take_rel;

  assign press_rel = head.rel;
  assign take_rel  = clr_rel & {N_BTN{push}};
  assign ovf_set   = |(fall & pend_press) | |(rise & pend_rel);
`else
  logic rise_unused;

  assign press_rel   = 1'b0;
  assign rise_unused = ^rise;
  assign ovf_set     = |(fall & pend_press);
`endif

  assign take_press = clr_press & {N_BTN{push}};

  // presses by index first, then releases by index
  always_comb begin
    sel_valid = 1'b0;
    sel_evt   = '0;
    clr_press = '0;
`ifdef WHACK_RELEASE_EVT_EN
    clr_rel   = '0;
`endif
    for (int i = 0; i < N_BTN; i++) begin
      if (!sel_valid && pend_press[i]) begin
        sel_valid    = 1'b1;
        sel_evt.id   = EVT_ID_W'(i);
        clr_press[i] = 1'b1;
      end
    end
`ifdef WHACK_RELEASE_EVT_EN
    for (int i = 0; i < N_BTN; i++) begin
      if (!sel_valid && pend_rel[i]) begin
        sel_valid  = 1'b1;
        sel_evt.rel = 1'b1;
        sel_evt.id = EVT_ID_W'(i);
        clr_rel[i] = 1'b1;
      end
    end
`endif
  end

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wptr] <= sel_evt;
        wptr      <= nxt(wptr);
      end
      if (pop) begin
        rptr <= nxt(rptr);
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // a flip while the channel's event is still pending is dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_press <= '0;
      overflow   <= 1'b0;
    end else begin
      pend_press <= (pend_press & ~take_press)
                  | (fall & ~pend_press);
      if (ovf_set) begin
        overflow <= 1'b1;
      end else if (clear_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

`ifdef WHACK_RELEASE_EVT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_rel <= '0;
    end else begin
      pend_rel <= (pend_rel & ~take_rel)
                | (rise & ~pend_rel);
    end
  end
`endif

endmodule

// File: tb/tb_whack_btn_events.sv
// Bench for whack_btn_events: vector table, corner sequences, random run
// checked every cycle against a queue-based reference model.
module tb_whack_btn_events;
  import whack_pkg::*;

  localparam int N     = 4;
  localparam int D     = DEBOUNCE_SIM;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [N-1:0]     btn_n = '1;
  logic [N-1:0]     held;
  logic             press_valid;
  logic             press_ready = 1'b0;
  logic [ID_W(N)-1:0] press_id;
  logic             press_rel;
  logic             overflow;
  logic             clear_overflow = 1'b0;

  always #5 clk = ~clk;

  whack_btn_events #(
    .N_BTN          (N),
    .DEBOUNCE_CYCLES(D),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_n         (btn_n),
    .held          (held),
    .press_valid   (press_valid),
    .press_ready   (press_ready),
    .press_id      (press_id),
    .press_rel     (press_rel),
    .overflow      (overflow),
    .clear_overflow(clear_overflow)
  );

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model: s2 is the pin two samples ago; a level is accepted
  // after D consecutive mismatching samples; events live in a queue.
  bit ms1 [N];
  bit ms2 [N];
  bit mst [N];
  int mrun [N];
  bit mpp [N];
  bit mpr [N];
  bit newp [N];
  bit newr [N];
  int mq [$];
  bit movf;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        ms1[i] = 1; ms2[i] = 1; mst[i] = 1;
        mrun[i] = 0; mpp[i] = 0; mpr[i] = 0;
      end
      mq.delete();
      movf = 0;
    end else begin
      bit pop, sovf;
      int sel;
      sovf = 0;
      for (int i = 0; i < N; i++) begin
        newp[i] = 0; newr[i] = 0;
        if (ms2[i] != mst[i]) begin
          mrun[i]++;
          if (mrun[i] == D) begin
            mst[i] = ms2[i];
            mrun[i] = 0;
            newp[i] = !mst[i];
            newr[i] = mst[i];
          end
        end else begin
          mrun[i] = 0;
        end
        ms2[i] = ms1[i];
        ms1[i] = btn_n[i];
      end
      for (int i = 0; i < N; i++) begin
        if (newp[i] && mpp[i]) sovf = 1;
        newp[i] = newp[i] && !mpp[i];
`ifdef WHACK_RELEASE_EVT_EN
        if (newr[i] && mpr[i]) sovf = 1;
        newr[i] = newr[i] && !mpr[i];
`else
        newr[i] = 0;
`endif
      end
      pop = (mq.size() > 0) && press_ready;
      sel = -1;
      if (mq.size() < DEPTH || pop) begin
        for (int i = 0; i < N; i++)
          if (sel < 0 && mpp[i]) sel = i;
        for (int i = 0; i < N; i++)
          if (sel < 0 && mpr[i]) sel = 8 + i;
      end
      if (pop) void'(mq.pop_front());
      if (sel >= 8) begin
        mq.push_back(sel);
        mpr[sel-8] = 0;
      end else if (sel >= 0) begin
        mq.push_back(sel);
        mpp[sel] = 0;
      end
      for (int i = 0; i < N; i++) begin
        if (newp[i]) mpp[i] = 1;
        if (newr[i]) mpr[i] = 1;
      end
      if (sovf) movf = 1;
      else if (clear_overflow) movf = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int eh;
      eh = 0;
      for (int i = 0; i < N; i++)
        if (!mst[i]) eh |= (1 << i);
      chk("m_held", int'(held), eh);
      chk("m_valid", int'(press_valid), int'(mq.size() > 0));
      chk("m_ovf", int'(overflow), int'(movf));
      if (mq.size() > 0) begin
        chk("m_id", int'(press_id), mq[0] % 8);
        chk("m_rel", int'(press_rel), int'(mq[0] >= 8));
      end
    end
  end

  typedef struct {
    logic [N-1:0] btn;
    logic         rdy;
    int           cyc;
    logic [N-1:0] held;
    logic         valid;
    int           id;
  } vec_t;

  vec_t tv [10];
  int   exp_ord [6] = '{0, 1, 2, 3, 0, 1};
  int   got [$];

  task automatic tap(input int ch);
    btn_n[ch] = 1'b0;
    step(10);
    btn_n[ch] = 1'b1;
    step(10);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    tv[0] = '{4'b1111, 1'b0, 5,  4'b0000, 1'b0, 0};
    tv[1] = '{4'b1011, 1'b0, 6,  4'b0100, 1'b0, 0};
    tv[2] = '{4'b1011, 1'b0, 1,  4'b0100, 1'b1, 2};
    tv[3] = '{4'b1011, 1'b0, 3,  4'b0100, 1'b1, 2};
    tv[4] = '{4'b1011, 1'b1, 1,  4'b0100, 1'b0, 0};
    tv[5] = '{4'b1111, 1'b1, 10, 4'b0000, 1'b0, 0};
    tv[6] = '{4'b0101, 1'b0, 7,  4'b1010, 1'b1, 1};
    tv[7] = '{4'b0101, 1'b1, 1,  4'b1010, 1'b1, 3};
    tv[8] = '{4'b0101, 1'b1, 1,  4'b1010, 1'b0, 0};
    tv[9] = '{4'b1111, 1'b1, 10, 4'b0000, 1'b0, 0};

    step(3);
    reset = 1'b0;
    chk_en = 1;
    chk("rst_held", int'(held), 0);
    chk("rst_valid", int'(press_valid), 0);
    chk("rst_id", int'(press_id), 0);
    chk("rst_rel", int'(press_rel), 0);
    chk("rst_ovf", int'(overflow), 0);

    for (int v = 0; v < 10; v++) begin
      btn_n = tv[v].btn;
      press_ready = tv[v].rdy;
      step(tv[v].cyc);
      chk($sformatf("tv%0d_held", v), int'(held), int'(tv[v].held));
      chk($sformatf("tv%0d_valid", v), int'(press_valid),
          int'(tv[v].valid));
      if (tv[v].valid)
        chk($sformatf("tv%0d_id", v), int'(press_id), tv[v].id);
    end

`ifndef WHACK_RELEASE_EVT_EN
    // bounce shorter than the debounce window
    press_ready = 1'b1;
    for (int t = 0; t < 10; t++) begin
      btn_n[0] = ~btn_n[0];
      step(2);
    end
    btn_n[0] = 1'b1;
    step(10);
    chk("bounce_held", int'(held[0]), 0);
    chk("bounce_valid", int'(press_valid), 0);

    // backpressure: four queued, two pending
    press_ready = 1'b0;
    for (int t = 0; t < 6; t++) tap(exp_ord[t]);
    chk("bp_ovf", int'(overflow), 0);
    chk("bp_valid", int'(press_valid), 1);
    press_ready = 1'b1;
    got.delete();
    for (int c = 0; c < 20 && got.size() < 6; c++) begin
      if (press_valid) got.push_back(int'(press_id));
      step(1);
    end
    chk("bp_count", got.size(), 6);
    for (int t = 0; t < 6; t++)
      chk($sformatf("bp_ord%0d", t),
          (t < got.size()) ? got[t] : -1, exp_ord[t]);

    // overflow: same channel flips twice while its press is pending
    press_ready = 1'b0;
    for (int t = 0; t < 4; t++) tap(t);
    tap(0);
    chk("ovf_pre", int'(overflow), 0);
    btn_n[0] = 1'b0;
    step(10);
    chk("ovf_set", int'(overflow), 1);
    btn_n[0] = 1'b1;
    step(10);
    chk("ovf_hold", int'(overflow), 1);
    clear_overflow = 1'b1;
    step(1);
    clear_overflow = 1'b0;
    chk("ovf_clr", int'(overflow), 0);
    press_ready = 1'b1;
    step(12);
    chk("ovf_drain", int'(press_valid), 0);

    // reset while a press is mid-debounce
    btn_n[1] = 1'b0;
    step(4);
    reset = 1'b1;
    btn_n = '1;
    step(1);
    reset = 1'b0;
    chk("mrst_held", int'(held), 0);
    chk("mrst_valid", int'(press_valid), 0);
    step(20);
    chk("mrst_late_held", int'(held), 0);
    chk("mrst_late_valid", int'(press_valid), 0);
`endif

    for (int blk = 0; blk < 6; blk++) begin
      int pct;
      pct = (blk % 2 == 1) ? 20 : 85;
      for (int c = 0; c < 500; c++) begin
        for (int i = 0; i < N; i++)
          if ($urandom_range(15) == 0) btn_n[i] = ~btn_n[i];
        press_ready = ($urandom_range(99) < pct);
        clear_overflow = ($urandom_range(31) == 0);
        step(1);
      end
    end

    btn_n = '1;
    press_ready = 1'b1;
    clear_overflow = 1'b0;
    step(30);
    chk("end_valid", int'(press_valid), 0);
    chk("end_held", int'(held), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
